core_sequencer: RTL

//  Multi-cycle control FSM for the core: drives the shared 3-bit state bus
//  (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4) consumed by decoder, ALU/FPU, memory and regfile.

---
 rtl/core_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle core control FSM: FETCH/DECODE/EXEC/MEM/WRITE with FPU and memory/UART stalls.
// Optional single-step gating of FETCH->DECODE when SEQ_STEP_EN is defined.
module core_sequencer #(
  parameter int unsigned FPU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  output logic [2:0]       state,
  input  logic             use_fpu,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             data_in,
  input  logic             data_out,
  output logic             fpu_start,
  input  logic             fpu_done,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             io_req,
  input  logic             io_ack,
  output logic             pc_we,
  output logic             wb_en,
  output logic             fatal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam int unsigned CW = (FPU_TIMEOUT > 2) ? $clog2(FPU_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FPU_TIMEOUT - 1);

  state_t        cur, nxt;
  logic [CW-1:0] exec_cnt;
  logic          flag_mem, flag_io;
  logic          exec_first;
  logic          go;

`ifdef SEQ_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  // Only an edge seen while parked in FETCH launches an instruction.
  assign go = run & step & ~step_q;
`else
  assign go = run;
`endif

  assign exec_first = (exec_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= FETCH;
      exec_cnt <= '0;
      flag_mem <= 1'b0;
      flag_io  <= 1'b0;
      fatal    <= 1'b0;
      retired  <= '0;
    end else begin
      cur <= nxt;
      if (cur == EXEC && nxt == EXEC) exec_cnt <= exec_cnt + CW'(1);
      else                            exec_cnt <= '0;
      // data_in/data_out are only valid in the first EXEC cycle, so capture there.
      if (cur == EXEC && exec_first) begin
        flag_mem <= mem_read | mem_write;
        flag_io  <= data_in | data_out;
      end
      if (cur != HALT && nxt == HALT) fatal <= 1'b1;
      if (cur == WRITE) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nxt       = cur;
    fpu_start = 1'b0;
    mem_req   = 1'b0;
    io_req    = 1'b0;
    pc_we     = 1'b0;
    wb_en     = 1'b0;
    case (cur)
      FETCH:  if (go) nxt = DECODE;
      DECODE: nxt = EXEC;
      EXEC: begin
        if (use_fpu) begin
          fpu_start = exec_first;
          if (fpu_done)                  nxt = MEM;
          else if (exec_cnt == CNT_LAST) nxt = HALT;
        end else begin
          nxt = MEM;
        end
      end
      MEM: begin
        if (flag_mem) begin
          mem_req = 1'b1;
          if (mem_ack) nxt = WRITE;
        end else if (flag_io) begin
          io_req = 1'b1;
          if (io_ack) nxt = WRITE;
        end else begin
          nxt = WRITE;
        end
      end
      WRITE: begin
        pc_we = 1'b1;
        wb_en = 1'b1;
        nxt   = FETCH;
      end
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
  end

  assign state = cur;

endmodule
